// File: rtl/rd_selh.sv
// rd_selh: half-word read selector for the load path.
// Picks the lower or upper half of a memory read word, zero- or sign-extends
// it to full width and registers the result with a one-cycle valid flag.
module rd_selh #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              in_valid,
    input  logic              is_signed,
    input  logic              sel,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    localparam int HALF_W = DATA_W / 2;

    // Extend a half-word to full width; the fill bit is the half's MSB only
    // when a signed load is requested, otherwise zero.
    function automatic logic [DATA_W-1:0] extend_half(
        input logic [HALF_W-1:0] half,
        input logic              sign_en
    );
        logic fill;
        fill = sign_en & half[HALF_W-1];
        return {{HALF_W{fill}}, half};
    endfunction

    logic [HALF_W-1:0] half_s;
    logic [DATA_W-1:0] ext_s;
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;
    logic              valid_d;
    logic              valid_q;

    // Select the requested half of the read word and extend it.
    always_comb begin
        half_s = in[HALF_W-1:0];
        if (sel == 1'b1) begin
            half_s = in[DATA_W-1:HALF_W];
        end else begin
            half_s = in[HALF_W-1:0];
        end
        ext_s = extend_half(half_s, is_signed);
    end

    // Next-state: capture a new result on in_valid, otherwise hold the data
    // so that undefined inputs during idle cycles cannot disturb it.
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (in_valid == 1'b1) begin
            out_d   = ext_s;
            valid_d = 1'b1;
        end else begin
            out_d   = out_q;
            valid_d = 1'b0;
        end
    end

    // Output register; reset wins over a simultaneous valid input.
    always_ff @(posedge clk) begin
        if (srst == 1'b1) begin
            out_q   <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rd_selh.sv
// tb_rd_selh: directed-vector self-checking bench for rd_selh.
module tb_rd_selh;

    logic        clk;
    logic        srst;
    logic        in_valid;
    logic        is_signed;
    logic        sel;
    logic [31:0] in;
    logic [31:0] out;
    logic        out_valid;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    rd_selh #(.DATA_W(32)) dut (
        .clk       (clk),
        .srst      (srst),
        .in_valid  (in_valid),
        .is_signed (is_signed),
        .sel       (sel),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt = checks_cnt + 1;
        if (obs !== exp_v) begin
            failures_cnt = failures_cnt + 1;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then check both outputs.
    task automatic step(input string tag, input logic rst_v, input logic vld_v,
                        input logic sel_v, input logic sgn_v, input logic [31:0] in_v,
                        input logic [31:0] exp_out, input logic exp_vld);
        srst      = rst_v;
        in_valid  = vld_v;
        sel       = sel_v;
        is_signed = sgn_v;
        in        = in_v;
        @(posedge clk);
        #1;
        check_val({tag, ".out"}, out, exp_out);
        check_val({tag, ".vld"}, {31'b0, out_valid}, {31'b0, exp_vld});
    endtask

    initial begin
        srst      = 1'b1;
        in_valid  = 1'b1;
        sel       = 1'b0;
        is_signed = 1'b0;
        in        = 32'hFFFF_FFFF;

        // Reset held for two cycles with a valid input present.
        step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        step("rst1", 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

        // Lower and upper halves, zero and sign extension.
        step("lo_u",  1'b0, 1'b1, 1'b0, 1'b0, 32'h788E_FD0C, 32'h0000_FD0C, 1'b1);
        step("lo_s",  1'b0, 1'b1, 1'b0, 1'b1, 32'h788E_FD0C, 32'hFFFF_FD0C, 1'b1);
        step("hip_u", 1'b0, 1'b1, 1'b1, 1'b0, 32'h788E_FD0C, 32'h0000_788E, 1'b1);
        step("hip_s", 1'b0, 1'b1, 1'b1, 1'b1, 32'h788E_FD0C, 32'h0000_788E, 1'b1);
        step("hin_s", 1'b0, 1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 32'hFFFF_8001, 1'b1);
        step("hin_u", 1'b0, 1'b1, 1'b1, 1'b0, 32'h8001_7FFF, 32'h0000_8001, 1'b1);
        step("lop_s", 1'b0, 1'b1, 1'b0, 1'b1, 32'h8001_7FFF, 32'h0000_7FFF, 1'b1);

        // Unselected half must not leak into the result.
        step("unsel", 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_1234, 32'h0000_1234, 1'b1);

        // Hold: result retained and valid dropped while in_valid is low.
        step("ld",    1'b0, 1'b1, 1'b0, 1'b1, 32'h788E_FD0C, 32'hFFFF_FD0C, 1'b1);
        step("hold0", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FD0C, 1'b0);
        step("hold1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FD0C, 1'b0);

        // Back-to-back: all four sel/is_signed combinations in consecutive cycles.
        step("b2b0", 1'b0, 1'b1, 1'b0, 1'b0, 32'hC3C3_A5A5, 32'h0000_A5A5, 1'b1);
        step("b2b1", 1'b0, 1'b1, 1'b0, 1'b1, 32'hC3C3_A5A5, 32'hFFFF_A5A5, 1'b1);
        step("b2b2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h5A5A_8000, 32'h0000_5A5A, 1'b1);
        step("b2b3", 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFE_0001, 32'hFFFF_FFFE, 1'b1);

        // Reset colliding with a valid input drops the input.
        step("coll",  1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_8000, 32'h0000_0000, 1'b0);
        step("idle",  1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        step("post",  1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_8000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
